// File: rtl/fg_burst_gen.sv
// Flow-generator burst scheduler: turns one flow descriptor into a paced stream
// of burst descriptors for the packet generator, with enable/abort control.
module fg_burst_gen #(
  parameter int DEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  input_fd_valid,
  output logic                  input_fd_ready,
  input  logic [DEST_WIDTH-1:0] input_fd_dest,
  input  logic [31:0]           input_fd_burst_len,
  input  logic [15:0]           input_fd_burst_count,
  input  logic [31:0]           input_fd_burst_interval,
  output logic                  output_bd_valid,
  input  logic                  output_bd_ready,
  output logic [DEST_WIDTH-1:0] output_bd_dest,
  output logic [31:0]           output_bd_burst_len,
  input  logic                  enable,
  input  logic                  abort,
  output logic                  busy,
  output logic [31:0]           bursts_sent
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_r;
  logic        started_r;
  logic [15:0] remaining_r;
  logic [31:0] interval_r;
  logic [31:0] timer_r;

  // started_r keeps the descriptor port closed until the first edge after reset release
  assign input_fd_ready = started_r & (state_r == ST_IDLE) & enable & ~abort;

  // Flow scheduler: accepts a descriptor, issues bursts, paces them by the interval timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r             <= ST_IDLE;
      started_r           <= 1'b0;
      remaining_r         <= 16'd0;
      interval_r          <= 32'd0;
      timer_r             <= 32'd0;
      output_bd_valid     <= 1'b0;
      output_bd_dest      <= {DEST_WIDTH{1'b0}};
      output_bd_burst_len <= 32'd0;
      busy                <= 1'b0;
      bursts_sent         <= 32'd0;
    end else begin
      started_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          // A zero-count descriptor is consumed without leaving IDLE
          if (input_fd_valid && input_fd_ready && (input_fd_burst_count != 16'd0)) begin
            output_bd_dest      <= input_fd_dest;
            output_bd_burst_len <= input_fd_burst_len;
            remaining_r         <= input_fd_burst_count;
            interval_r          <= input_fd_burst_interval;
            output_bd_valid     <= 1'b1;
            busy                <= 1'b1;
            state_r             <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (output_bd_ready) begin
            bursts_sent <= bursts_sent + 32'd1;
            remaining_r <= remaining_r - 16'd1;
            if ((remaining_r == 16'd1) || abort) begin
              output_bd_valid <= 1'b0;
              busy            <= 1'b0;
              state_r         <= ST_IDLE;
            end else if (interval_r > 32'd1) begin
              output_bd_valid <= 1'b0;
              timer_r         <= interval_r - 32'd1;
              state_r         <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Timer parks at 1 while enable is low; that is the pause point
          if (abort) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (timer_r > 32'd1) begin
            timer_r <= timer_r - 32'd1;
          end else if (enable) begin
            output_bd_valid <= 1'b1;
            state_r         <= ST_ISSUE;
          end
        end
        default: begin
          output_bd_valid <= 1'b0;
          busy            <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
